// File: rtl/button_debounce_counter.sv
// N-channel button front end: 2-flop sync, debounce, press-edge pulse, shared press counter on the LEDs.
// Define HOLD_REPEAT_EN to emit auto-repeat press pulses every REPEAT_CYCLES while a button is held.
module button_debounce_counter #(
   parameter int NUM_BUTTONS     = 2,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int COUNT_WIDTH     = 6,
   parameter int REPEAT_CYCLES   = 64
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic [NUM_BUTTONS-1:0] buttons,
   input  logic                   saturate,
   input  logic                   clearCount,
   output logic [NUM_BUTTONS-1:0] stable,
   output logic [NUM_BUTTONS-1:0] pressPulse,
   output logic [COUNT_WIDTH-1:0] leds,
   output logic                   testButton
);

   localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam int              SUM_W   = COUNT_WIDTH + 4;
   localparam int              INC_W   = $clog2(NUM_BUTTONS + 1);

   genvar gi;

   // Elaboration-time guards on the legal parameter ranges.
   generate
      if (NUM_BUTTONS < 1 || NUM_BUTTONS > 8) begin : g_bad_num_buttons
         $error("button_debounce_counter: NUM_BUTTONS must be within 1..8");
      end
      if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
         $error("button_debounce_counter: DEBOUNCE_CYCLES must be at least 2");
      end
      if (REPEAT_CYCLES < 2) begin : g_bad_repeat
         $error("button_debounce_counter: REPEAT_CYCLES must be at least 2");
      end
   endgenerate

   generate
      for (gi = 0; gi < NUM_BUTTONS; gi++) begin : g_chan
         logic            sync1_reg;
         logic            sync2_reg;
         logic            stable_reg;
         logic            stable_next;
         logic            pulse_reg;
         logic            pulse_next;
         logic            repeat_fire;
         logic [DB_W-1:0] db_cnt_reg;
         logic [DB_W-1:0] db_cnt_next;

         // A differing level must survive DEBOUNCE_CYCLES consecutive samples; any bounce restarts.
         always_comb begin
            stable_next = stable_reg;
            db_cnt_next = '0;
            if (sync2_reg != stable_reg) begin
               if (db_cnt_reg == DB_LAST) begin
                  stable_next = sync2_reg;
               end else begin
                  db_cnt_next = db_cnt_reg + 1'b1;
               end
            end
         end

`ifdef HOLD_REPEAT_EN
         localparam int              RP_W    = $clog2(REPEAT_CYCLES + 1);
         localparam logic [RP_W-1:0] RP_LAST = RP_W'(REPEAT_CYCLES - 1);

         logic [RP_W-1:0] rp_cnt_reg;
         logic [RP_W-1:0] rp_cnt_next;

         // Clearing on the firing edge keeps repeats exactly REPEAT_CYCLES apart from the press pulse.
         always_comb begin
            rp_cnt_next = '0;
            repeat_fire = 1'b0;
            if (stable_reg) begin
               if (rp_cnt_reg == RP_LAST) begin
                  repeat_fire = 1'b1;
               end else begin
                  rp_cnt_next = rp_cnt_reg + 1'b1;
               end
            end
         end

         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
               rp_cnt_reg <= '0;
            end else begin
               rp_cnt_reg <= rp_cnt_next;
            end
         end
`else
         assign repeat_fire = 1'b0;
`endif

         assign pulse_next = (stable_next & ~stable_reg) | repeat_fire;

         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
               sync1_reg  <= 1'b0;
               sync2_reg  <= 1'b0;
               stable_reg <= 1'b0;
               pulse_reg  <= 1'b0;
               db_cnt_reg <= '0;
            end else begin
               sync1_reg  <= buttons[gi];
               sync2_reg  <= sync1_reg;
               stable_reg <= stable_next;
               pulse_reg  <= pulse_next;
               db_cnt_reg <= db_cnt_next;
            end
         end

         assign stable[gi]     = stable_reg;
         assign pressPulse[gi] = pulse_reg;
      end
   endgenerate

   logic [INC_W-1:0]       inc;
   logic [SUM_W-1:0]       sum;
   logic [COUNT_WIDTH-1:0] leds_reg;
   logic [COUNT_WIDTH-1:0] leds_next;

   always_comb begin
      inc = '0;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
         inc = inc + INC_W'(pressPulse[i]);
      end
   end

   // Wide sum exposes overflow above the LED range before wrapping or clamping.
   always_comb begin
      sum = SUM_W'(leds_reg) + SUM_W'(inc);
      if (clearCount) begin
         leds_next = '0;
      end else if (saturate && (|sum[SUM_W-1:COUNT_WIDTH])) begin
         leds_next = '1;
      end else begin
         leds_next = sum[COUNT_WIDTH-1:0];
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         leds_reg <= '0;
      end else begin
         leds_reg <= leds_next;
      end
   end

   assign leds       = leds_reg;
   assign testButton = stable[0];

endmodule

// File: tb/tb_button_debounce_counter.sv
// Directed bench for button_debounce_counter: expectations queued as stimulus is driven, popped at check points.
// The held-button pulse total depends on whether HOLD_REPEAT_EN is defined for the build.
`timescale 1ns/1ps
module tb_button_debounce_counter;

   localparam int NB = 2;
   localparam int DC = 4;
   localparam int CW = 6;
   localparam int RC = 8;
   localparam int LED_MAX = (1 << CW) - 1;

   logic          clock      = 1'b0;
   logic          reset_n    = 1'b0;
   logic [NB-1:0] buttons    = '0;
   logic          saturate   = 1'b0;
   logic          clearCount = 1'b0;
   logic [NB-1:0] stable;
   logic [NB-1:0] pressPulse;
   logic [CW-1:0] leds;
   logic          testButton;

   int    checks   = 0;
   int    errors   = 0;
   int    exp_leds = 0;
   int    pulse_cnt0 = 0;
   int    pulse_cnt1 = 0;
   int    base0;
   int    base1;
   int    hold_pulses;
   logic [31:0] exp_q[$];
   string       tag_q[$];

   always #5 clock = ~clock;

   button_debounce_counter #(
      .NUM_BUTTONS    (NB),
      .DEBOUNCE_CYCLES(DC),
      .COUNT_WIDTH    (CW),
      .REPEAT_CYCLES  (RC)
   ) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .buttons   (buttons),
      .saturate  (saturate),
      .clearCount(clearCount),
      .stable    (stable),
      .pressPulse(pressPulse),
      .leds      (leds),
      .testButton(testButton)
   );

   always @(negedge clock) begin
      if (pressPulse[0]) pulse_cnt0 <= pulse_cnt0 + 1;
      if (pressPulse[1]) pulse_cnt1 <= pulse_cnt1 + 1;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic expect_val(input string tag, input int val);
      tag_q.push_back(tag);
      exp_q.push_back(32'(val));
   endtask

   task automatic check(input logic [31:0] observed);
      string       tag;
      logic [31:0] expected;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $error("FAIL scoreboard_empty: observed %0d with no expected value queued", observed);
         return;
      end
      tag      = tag_q.pop_front();
      expected = exp_q.pop_front();
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Full press/release cycle; the button is released one cycle after acceptance so no repeat can fire.
   task automatic press(input logic [NB-1:0] mask);
      int k;
      k = $countones(mask);
      if (saturate) exp_leds = (exp_leds + k > LED_MAX) ? LED_MAX : exp_leds + k;
      else          exp_leds = (exp_leds + k) % (LED_MAX + 1);
      buttons = buttons | mask;
      tick(7);
      buttons = buttons & ~mask;
      tick(8);
   endtask

   initial begin
      // Reset state
      #2;
      expect_val("reset_stable", 0);
      expect_val("reset_pulse", 0);
      expect_val("reset_leds", 0);
      expect_val("reset_testButton", 0);
      check(32'(stable));
      check(32'(pressPulse));
      check(32'(leds));
      check(32'(testButton));
      tick(2);
      reset_n = 1'b1;

      // Clean press on channel 0
      buttons[0] = 1'b1;
      expect_val("clean_stable_edge4", 0);
      expect_val("clean_stable_edge5", 1);
      expect_val("clean_testButton", 1);
      expect_val("clean_pulse", 1);
      expect_val("clean_leds_same_cycle", 0);
      expect_val("clean_pulse_width", 0);
      expect_val("clean_leds", 1);
      tick(5);
      check(32'(stable[0]));
      tick(1);
      check(32'(stable[0]));
      check(32'(testButton));
      check(32'(pressPulse));
      check(32'(leds));
      tick(1);
      check(32'(pressPulse));
      check(32'(leds));
      exp_leds = 1;
      buttons[0] = 1'b0;
      expect_val("clean_release_stable", 0);
      expect_val("clean_release_no_pulse", 1);
      expect_val("clean_release_leds", 1);
      tick(8);
      check(32'(stable[0]));
      check(32'(pulse_cnt0));
      check(32'(leds));

      // Bounce: toggling every 3 cycles never gets accepted
      clearCount = 1'b1;
      expect_val("clear_leds", 0);
      tick(1);
      clearCount = 1'b0;
      check(32'(leds));
      exp_leds = 0;
      base0 = pulse_cnt0;
      expect_val("bounce_no_pulse", 0);
      expect_val("bounce_stable_low", 0);
      for (int i = 0; i < 10; i++) begin
         buttons[0] = ~buttons[0];
         tick(3);
      end
      check(32'(pulse_cnt0 - base0));
      check(32'(stable[0]));
      buttons[0] = 1'b1;
      expect_val("bounce_pre_accept", 0);
      expect_val("bounce_pulse", 1);
      expect_val("bounce_leds", 1);
      expect_val("bounce_pulse_total", 1);
      tick(5);
      check(32'(pressPulse));
      tick(1);
      check(32'(pressPulse));
      tick(1);
      check(32'(leds));
      buttons[0] = 1'b0;
      tick(8);
      check(32'(pulse_cnt0 - base0));

      // Simultaneous press on both channels adds 2 in one step
      clearCount = 1'b1;
      tick(1);
      clearCount = 1'b0;
      base1 = pulse_cnt1;
      buttons = 2'b11;
      expect_val("simul_pulse", 3);
      expect_val("simul_leds_before", 0);
      expect_val("simul_leds_after", 2);
      tick(6);
      check(32'(pressPulse));
      check(32'(leds));
      tick(1);
      check(32'(leds));
      buttons = 2'b00;
      expect_val("simul_ch1_pulses", 1);
      tick(8);
      check(32'(pulse_cnt1 - base1));
      exp_leds = 2;

      // Wrap: climb to max with saturate off, then one more press wraps to 0
      saturate = 1'b0;
      for (int i = 0; i < 30; i++) press(2'b11);
      press(2'b01);
      expect_val("wrap_at_max", LED_MAX);
      check(32'(leds));
      press(2'b01);
      expect_val("wrap_to_zero", exp_leds);
      check(32'(leds));

      // Saturate: the final double press from max-1 clamps, further presses stay at max
      saturate = 1'b1;
      for (int i = 0; i < 32; i++) press(2'b11);
      expect_val("sat_clamp", LED_MAX);
      check(32'(leds));
      press(2'b01);
      expect_val("sat_hold_single", LED_MAX);
      check(32'(leds));
      press(2'b11);
      expect_val("sat_hold_double", exp_leds);
      check(32'(leds));

      // clearCount coincident with a press pulse wins
      buttons[0] = 1'b1;
      expect_val("clr_pulse_present", 1);
      expect_val("clr_leds", 0);
      expect_val("clr_leds_next", 0);
      tick(6);
      check(32'(pressPulse));
      clearCount = 1'b1;
      tick(1);
      clearCount = 1'b0;
      check(32'(leds));
      tick(1);
      check(32'(leds));
      buttons[0] = 1'b0;
      tick(8);
      exp_leds = 0;

      // Asynchronous reset mid-debounce
      saturate = 1'b0;
      for (int i = 0; i < 5; i++) press(2'b01);
      expect_val("prereset_leds", 5);
      check(32'(leds));
      buttons[0] = 1'b1;
      tick(4);
      #2;
      reset_n = 1'b0;
      #1;
      expect_val("areset_leds", 0);
      expect_val("areset_stable", 0);
      expect_val("areset_pulse", 0);
      expect_val("areset_testButton", 0);
      check(32'(leds));
      check(32'(stable));
      check(32'(pressPulse));
      check(32'(testButton));
      tick(2);
      reset_n = 1'b1;
      expect_val("post_reset_edge4", 0);
      expect_val("post_reset_edge5", 1);
      expect_val("post_reset_leds", 1);
      tick(5);
      check(32'(stable[0]));
      tick(1);
      check(32'(stable[0]));
      tick(1);
      check(32'(leds));
      buttons[0] = 1'b0;
      tick(8);

      // Long hold: auto-repeat pulses only when the feature is built in
`ifdef HOLD_REPEAT_EN
      hold_pulses = 5;
`else
      hold_pulses = 1;
`endif
      clearCount = 1'b1;
      tick(1);
      clearCount = 1'b0;
      base0 = pulse_cnt0;
      buttons[0] = 1'b1;
      expect_val("hold_pulses", hold_pulses);
      expect_val("hold_leds", hold_pulses);
      expect_val("hold_release_stable", 0);
      tick(6);
      tick(32);
      buttons[0] = 1'b0;
      tick(10);
      check(32'(pulse_cnt0 - base0));
      check(32'(leds));
      check(32'(stable[0]));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
